async_rr_merge: RTL and testbench

- Round-robin scheduler that shares one downstream pull-handshake consumer port between N upstream producers.
- Upstream producers are `in` operators or any `async_operator` output; the downstream consumer is a single shared operator/`out` node.
- Pulls one word at a time from the selected source, then delivers it tagged with the source index.
- A per-source timeout skips stalled sources so one dead producer cannot starve the others.

---
 rtl/async_rr_merge.sv | 144 ++++++++++++++
 tb/tb_async_rr_merge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_rr_merge.sv
// rtl/async_rr_merge.sv - round-robin pull merge of N producers onto one consumer, with per-source timeout skip.
// Optional counters (grant_count, skip_count) are enabled by defining ASYNC_RR_MERGE_STATS_EN.
module async_rr_merge #(
  parameter int data_width = 32,
  parameter int num_inputs = 4,
  parameter int id_width   = 2,
  parameter int timeout    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic [num_inputs-1:0]              din_req,
  input  logic [num_inputs-1:0]              din_ack,
  input  logic [data_width*num_inputs-1:0]   din,
  input  logic                               dout_req,
  output logic                               dout_ack,
  output logic [data_width-1:0]              dout,
  output logic [id_width-1:0]                dout_id
`ifdef ASYNC_RR_MERGE_STATS_EN
  ,
  output logic [32*num_inputs-1:0]           grant_count,
  output logic [31:0]                        skip_count
`endif
);

  localparam int TW = $clog2(timeout);

  typedef enum logic [1:0] {FETCH, DRAIN, DELIVER} state_t;

  state_t                state, state_n;
  logic [id_width-1:0]   sel, sel_n, sel_inc, held_id, held_id_n, dout_id_n;
  logic [TW-1:0]         timer, timer_n;
  logic [num_inputs-1:0] din_req_n, sel_oh, inc_oh;
  logic [data_width-1:0] held, held_n, dout_n, sel_data;
  logic                  dout_ack_n, ack_hit;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < num_inputs; i++) begin
      if (sel == id_width'(i)) sel_data = din[i*data_width +: data_width];
    end
  end

  assign sel_inc = (sel == id_width'(num_inputs - 1)) ? '0 : sel + 1'b1;
  assign sel_oh  = num_inputs'(1) << sel;
  assign inc_oh  = num_inputs'(1) << sel_inc;
  // Acks from non-selected producers are masked out here and never seen by the FSM.
  assign ack_hit = |(din_ack & sel_oh);

  always_comb begin
    state_n    = state;
    sel_n      = sel;
    timer_n    = timer;
    din_req_n  = din_req;
    held_n     = held;
    held_id_n  = held_id;
    dout_ack_n = 1'b0;
    dout_n     = dout;
    dout_id_n  = dout_id;
    case (state)
      FETCH: begin
        if (ack_hit) begin
          held_n    = sel_data;
          held_id_n = sel;
          din_req_n = '0;
          timer_n   = '0;
          state_n   = DELIVER;
        end else if (din_req == '0) begin
          // first FETCH cycle after reset: raise the request, timer starts with it
          din_req_n = sel_oh;
        end else if (timer == TW'(timeout - 1)) begin
          din_req_n = '0;
          state_n   = DRAIN;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DRAIN: begin
        timer_n = '0;
        if (ack_hit) begin
          held_n    = sel_data;
          held_id_n = sel;
          state_n   = DELIVER;
        end else begin
          sel_n     = sel_inc;
          din_req_n = inc_oh;
          state_n   = FETCH;
        end
      end
      DELIVER: begin
        if (dout_ack) begin
          sel_n     = sel_inc;
          din_req_n = inc_oh;
          timer_n   = '0;
          state_n   = FETCH;
        end else if (dout_req) begin
          dout_ack_n = 1'b1;
          dout_n     = held;
          dout_id_n  = held_id;
        end
      end
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      sel      <= '0;
      timer    <= '0;
      din_req  <= '0;
      held     <= '0;
      held_id  <= '0;
      dout_ack <= 1'b0;
      dout     <= '0;
      dout_id  <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      timer    <= timer_n;
      din_req  <= din_req_n;
      held     <= held_n;
      held_id  <= held_id_n;
      dout_ack <= dout_ack_n;
      dout     <= dout_n;
      dout_id  <= dout_id_n;
    end
  end

`ifdef ASYNC_RR_MERGE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_count <= '0;
      skip_count  <= '0;
    end else begin
      if (state == DRAIN && !ack_hit) skip_count <= skip_count + 32'd1;
      for (int i = 0; i < num_inputs; i++) begin
        if (dout_ack && dout_id == id_width'(i))
          grant_count[i*32 +: 32] <= grant_count[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_async_rr_merge.sv
// tb/tb_async_rr_merge.sv - bench for async_rr_merge: producer models, delivery scoreboard, directed phases.
// Stats checks are compiled in when ASYNC_RR_MERGE_STATS_EN is defined.
module tb_async_rr_merge;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;
  localparam int M_NORMAL = 0;
  localparam int M_DEAD   = 1;
  localparam int M_LATE   = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   din_req;
  logic [N-1:0]   din_ack;
  logic [W*N-1:0] din;
  logic           dout_req;
  logic           dout_ack;
  logic [W-1:0]   dout;
  logic [1:0]     dout_id;
`ifdef ASYNC_RR_MERGE_STATS_EN
  logic [32*N-1:0] grant_count;
  logic [31:0]     skip_count;
`endif

  async_rr_merge #(.data_width(W), .num_inputs(N), .id_width(2), .timeout(TO)) dut (
    .clk(clk), .rst(rst), .din_req(din_req), .din_ack(din_ack), .din(din),
    .dout_req(dout_req), .dout_ack(dout_ack), .dout(dout), .dout_id(dout_id)
`ifdef ASYNC_RR_MERGE_STATS_EN
    , .grant_count(grant_count), .skip_count(skip_count)
`endif
  );

  int total = 0;
  int bad = 0;
  int mode [N];
  logic [N-1:0] spur_mask;
  int nwords;
  int q_id [$];
  int q_data [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Producers: normal ones ack the cycle after their request rises, late ones in the cycle after a full timeout window.
  initial begin
    logic [N-1:0] r, a;
    int pk [N];
    int prun [N];
    din_ack = '0;
    din = '0;
    for (int i = 0; i < N; i++) begin pk[i] = 0; prun[i] = 0; end
    forever begin
      @(negedge clk);
      r = din_req;
      a = din_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          pk[i] = 0; prun[i] = 0; din_ack[i] = 1'b0;
        end else begin
          case (mode[i])
            M_NORMAL: din_ack[i] = r[i] && !a[i];
            M_LATE: begin
              prun[i] = r[i] ? prun[i] + 1 : 0;
              din_ack[i] = (prun[i] == TO);
              if (din_ack[i]) prun[i] = 0;
            end
            default: din_ack[i] = 1'b0;
          endcase
          if (din_ack[i]) begin
            din[i*W +: W] = 10*i + pk[i];
            pk[i]++;
          end
          if (spur_mask[i]) begin
            din_ack[i] = 1'b1;
            din[i*W +: W] = 32'hdead_beef;
          end
        end
      end
    end
  end

  // Scoreboard: delivery order is round-robin over the sources that are not dead, data 10*id + per-source count.
  initial begin
    int model_sel;
    int model_k [N];
    int mrun [N];
    int eid;
    logic [W-1:0] last_dout;
    logic [1:0]   last_id;
    logic         prev_ack;
    model_sel = 0; nwords = 0; prev_ack = 0; last_dout = '0; last_id = '0;
    for (int i = 0; i < N; i++) begin model_k[i] = 0; mrun[i] = 0; end
    forever begin
      @(negedge clk);
      if (rst) begin
        model_sel = 0; nwords = 0; prev_ack = 0; last_dout = '0; last_id = '0;
        q_id.delete(); q_data.delete();
        for (int i = 0; i < N; i++) begin model_k[i] = 0; mrun[i] = 0; end
      end else begin
        check("req_onehot", $countones(din_req) <= 1, 1);
        check("ack_width", prev_ack && dout_ack, 0);
        if (dout_ack) begin
          eid = model_sel;
          for (int s = 0; s < N && mode[eid] == M_DEAD; s++) eid = (eid + 1) % N;
          check("dout_id", dout_id, eid);
          check("dout", dout, 10*eid + model_k[eid]);
          q_id.push_back(int'(dout_id));
          q_data.push_back(int'(dout));
          nwords++;
          model_k[eid]++;
          model_sel = (eid + 1) % N;
          last_dout = dout;
          last_id = dout_id;
        end else begin
          check("dout_hold", dout, last_dout);
          check("id_hold", dout_id, last_id);
        end
        prev_ack = dout_ack;
        for (int i = 0; i < N; i++) begin
          if (mode[i] != M_NORMAL) begin
            if (din_req[i]) mrun[i]++;
            else if (mrun[i] != 0) begin
              check("req_window", mrun[i], TO);
              mrun[i] = 0;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
    mode[0] = m0; mode[1] = m1; mode[2] = m2; mode[3] = m3;
  endtask

  task automatic wait_words(input int n, input int limit);
    int c = 0;
    while (nwords < n && c < limit) begin
      @(posedge clk); #2; c++;
    end
    check("wait_words", nwords >= n, 1);
  endtask

  task automatic wait_req_fall(input int i, input int limit);
    int c = 0;
    while (!din_req[i] && c < limit) begin @(posedge clk); #2; c++; end
    while (din_req[i] && c < limit) begin @(posedge clk); #2; c++; end
    check("wait_req_fall", c < limit, 1);
  endtask

  initial begin
    int t_req, t_ack, base;
    int exp_seq [6];
    rst = 1'b1;
    dout_req = 1'b0;
    spur_mask = '0;
    set_modes(M_NORMAL, M_NORMAL, M_NORMAL, M_NORMAL);

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_din_req", din_req, 0);
    check("rst_dout_ack", dout_ack, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_id", dout_id, 0);
`ifdef ASYNC_RR_MERGE_STATS_EN
    check("rst_grant", grant_count, 0);
    check("rst_skip", skip_count, 0);
`endif

    // all producers healthy, consumer always ready
    dout_req = 1'b1;
    do_reset();
    t_req = -1; t_ack = -1;
    for (int c = 1; c <= 1600; c++) begin
      @(posedge clk); #2;
      if (din_req[0] && t_req < 0) t_req = c;
      if (dout_ack && t_ack < 0) t_ack = c;
    end
    @(negedge clk); #1;
    check("first_latency", t_ack - t_req, 3);
    check("words_in_1600", nwords, 400);
    check("w0_id", q_id[0], 0);
    check("w0_data", q_data[0], 0);
    check("w1_id", q_id[1], 1);
    check("w1_data", q_data[1], 10);
    check("w5_data", q_data[5], 11);
`ifdef ASYNC_RR_MERGE_STATS_EN
    @(posedge clk); #2;
    for (int i = 0; i < N; i++) check("grant_100", grant_count[i*32 +: 32], 100);
    check("skip_0", skip_count, 0);
`endif

    // source 2 dead
    set_modes(M_NORMAL, M_NORMAL, M_DEAD, M_NORMAL);
    do_reset();
    wait_words(6, 300);
    exp_seq = '{0, 1, 3, 0, 1, 3};
    for (int k = 0; k < 6; k++) check("dead_seq", q_id[k], exp_seq[k]);
    check("dead_w2_data", q_data[2], 30);
`ifdef ASYNC_RR_MERGE_STATS_EN
    check("dead_skip", skip_count, 2);
`endif

    // source 1 acks in the drain cycle
    set_modes(M_NORMAL, M_LATE, M_NORMAL, M_NORMAL);
    do_reset();
    wait_words(4, 200);
    check("late_id", q_id[1], 1);
    check("late_data", q_data[1], 10);
    check("late_next_id", q_id[2], 2);
`ifdef ASYNC_RR_MERGE_STATS_EN
    check("late_skip", skip_count, 0);
`endif

    // consumer stalls after the first fetch
    set_modes(M_NORMAL, M_NORMAL, M_NORMAL, M_NORMAL);
    dout_req = 1'b0;
    do_reset();
    wait_req_fall(0, 50);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #2;
      check("stall_req", din_req, 0);
      check("stall_ack", dout_ack, 0);
    end
    dout_req = 1'b1;
    base = nwords;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("stall_pulses", nwords - base, 1);
    check("stall_id", q_id[base], 0);
    check("stall_data", q_data[base], 0);

    // spurious ack on source 3 while source 0 is selected
    do_reset();
    spur_mask = 4'b1000;
    @(posedge clk); #2;
    spur_mask = '0;
    wait_words(4, 100);
    check("spur_id", q_id[0], 0);
    check("spur_data", q_data[0], 0);
    check("spur_src3_data", q_data[3], 30);

    // reset while a word is held in DELIVER
    do_reset();
    wait_words(2, 100);
    dout_req = 1'b0;
    wait_req_fall(2, 50);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_req", din_req, 0);
    check("mid_rst_ack", dout_ack, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_id", dout_id, 0);
`ifdef ASYNC_RR_MERGE_STATS_EN
    check("mid_rst_grant", grant_count, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    dout_req = 1'b1;
    wait_words(1, 50);
    check("post_rst_id", q_id[0], 0);
    check("post_rst_data", q_data[0], 0);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
